// File: rtl/cnn_pkg.sv
// Shared constants, types and helpers for the CNN post-processing blocks.
package cnn_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int SAT_MAX    = 127;
    localparam int SAT_MIN    = -127;
    localparam int FIFO_DEPTH = 4;

    typedef logic signed [DATA_WIDTH-1:0] data_t;

    typedef struct packed {
        logic  last;
        data_t data;
    } pool_entry_t;

    function automatic data_t smax(input data_t a, input data_t b);
        return (b > a) ? b : a;
    endfunction
endpackage

// File: rtl/sync_fifo_4.sv
// Small synchronous FIFO (FIFO_DEPTH entries); a push into a full FIFO succeeds
// only when a pop happens in the same cycle, otherwise it is reported on drop.
module sync_fifo_4
    import cnn_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             drop
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             empty, full, push, pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        pop      = rd_en && !empty;
        push     = wr_en && (!full || pop);
        drop     = wr_en && full && !pop;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is gated to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign valid   = !empty;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/maxpool_relu_0.sv
// Max-pooling stage behind a fixed-latency conv element, with segment tagging and
// an output FIFO. Define POOL_RELU_EN to clamp negative conv outputs to zero first.
module maxpool_relu_0
    import cnn_pkg::*;
#(
    parameter int CONV_LATENCY = 6,
    parameter int POOL_SIZE    = 2,
    parameter int SEG_LEN      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] conv_y,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         overflow
);
    localparam int NUM_POOL = SEG_LEN / POOL_SIZE;
    localparam int WIN_W    = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam int SEG_W    = (NUM_POOL > 1) ? $clog2(NUM_POOL) : 1;

    logic [CONV_LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [WIN_W-1:0]        win_cnt_q, win_cnt_d;
    logic [SEG_W-1:0]        seg_cnt_q, seg_cnt_d;
    data_t                   run_max_q, run_max_d;
    logic                    overflow_q, overflow_d;

    logic        y_valid;
    data_t       sample;
    data_t       pooled;
    logic        win_last;
    logic        seg_last;
    logic        push;
    pool_entry_t push_entry;
    pool_entry_t head_entry;
    logic        fifo_drop;

    assign y_valid = vld_sr_q[CONV_LATENCY-1];

    always_comb begin
        sample = conv_y;
        if (conv_y > data_t'(SAT_MAX)) begin
            sample = data_t'(SAT_MAX);
        end else if (conv_y < data_t'(SAT_MIN)) begin
            sample = data_t'(SAT_MIN);
        end
`ifdef POOL_RELU_EN
        if (conv_y < 0) begin
            sample = '0;
        end
`endif
    end

    always_comb begin
        vld_sr_d   = (vld_sr_q << 1) | CONV_LATENCY'(in_valid);
        win_last   = (win_cnt_q == WIN_W'(POOL_SIZE - 1));
        seg_last   = (seg_cnt_q == SEG_W'(NUM_POOL - 1));
        pooled     = (win_cnt_q == '0) ? sample : smax(run_max_q, sample);
        win_cnt_d  = win_cnt_q;
        seg_cnt_d  = seg_cnt_q;
        run_max_d  = run_max_q;
        push       = 1'b0;
        push_entry = '{last: seg_last, data: pooled};
        if (y_valid) begin
            run_max_d = pooled;
            if (win_last) begin
                win_cnt_d = '0;
                push      = 1'b1;
                // Dropped results still count toward the segment so framing stays aligned.
                seg_cnt_d = seg_last ? '0 : seg_cnt_q + SEG_W'(1);
            end else begin
                win_cnt_d = win_cnt_q + WIN_W'(1);
            end
        end
        overflow_d = overflow_q | fifo_drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr_q   <= '0;
            win_cnt_q  <= '0;
            seg_cnt_q  <= '0;
            run_max_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            vld_sr_q   <= vld_sr_d;
            win_cnt_q  <= win_cnt_d;
            seg_cnt_q  <= seg_cnt_d;
            run_max_q  <= run_max_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo_4 #(
        .WIDTH($bits(pool_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (push_entry),
        .rd_en   (out_ready),
        .rd_data (head_entry),
        .valid   (out_valid),
        .drop    (fifo_drop)
    );

    assign out_data = head_entry.data;
    assign out_last = head_entry.last;
    assign overflow = overflow_q;
endmodule

// File: doc/maxpool_relu_0.md
MAXPOOL_RELU_0 -- requirements
Module: maxpool_relu_0

Interface
REQ-001 SHALL have parameter CONV_LATENCY, default 6: cycles from a sample entering the conv element to its registered Yout.
REQ-002 SHALL have parameter POOL_SIZE, default 2: conv outputs per pooling window (2..8).
REQ-003 SHALL have parameter SEG_LEN, default 16: conv outputs per ECG segment (multiple of POOL_SIZE).
REQ-004 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: sample driven into the conv element this cycle.
REQ-007 SHALL have port conv_y, input, 8 signed: conv element Yout, range [-127,127].
REQ-008 SHALL have port out_data, output, 8 signed: pooled result at FIFO head.
REQ-009 SHALL have port out_valid, output, 1: out_data valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts out_data.
REQ-011 SHALL have port out_last, output, 1: head entry is the final pooled result of a segment.
REQ-012 SHALL have port overflow, output, 1: sticky; a pooled result was dropped.

Function
REQ-013 SHALL delay in_valid through a CONV_LATENCY-deep shift register; the tap output (y_valid) qualifies conv_y in that cycle.
REQ-014 SHALL ignore conv_y in every cycle where y_valid is 0; the window and segment counters hold.
REQ-015 SHALL keep a window counter 0..POOL_SIZE-1 and a running max; the first valid sample of a window loads max, and later samples replace it only if strictly greater (signed compare).
REQ-016 SHALL produce one pooled result in the cycle the window counter wraps from POOL_SIZE-1 to 0; the result is max(running max, current sample).
REQ-017 SHALL keep a segment counter of pooled results 0..SEG_LEN/POOL_SIZE-1; the result that wraps it carries last=1.
REQ-018 SHALL push {last, result} into a 4-entry FIFO; out_valid = FIFO not empty; an entry pops on out_valid && out_ready.
REQ-019 SHALL make the FIFO accept a push into a full FIFO when a pop occurs in the same cycle.
REQ-020 SHALL, on a push into a full FIFO without a pop, drop the result, set overflow, and still advance the segment counter.
REQ-021 SHALL make pooled-result latency exactly 1 cycle: the final window sample on cycle N is visible at an empty FIFO head with out_valid=1 on cycle N+1.
REQ-022 SHALL clear overflow only by reset.

Reset
REQ-023 SHALL, while rst_n=0, clear the valid delay line, counters, running max, FIFO pointers and overflow asynchronously; out_valid=0, out_data=0, out_last=0.
REQ-024 SHALL, on reset mid-window or mid-segment, discard partial state, and the first y_valid sample after release starts a new window and segment.

Configuration
REQ-025 SHALL support macro POOL_RELU_EN: when defined, each valid conv_y is clamped to max(conv_y, 0) before pooling, so results are in [0,127].
REQ-026 SHALL, without POOL_RELU_EN, pool raw signed values, so results are in [-127,127].

Structure
REQ-027 SHALL place DATA_WIDTH (8), SAT_MAX (127), SAT_MIN (-127) and the FIFO depth constant (4) in the shared package cnn_pkg.
REQ-028 SHALL implement the FIFO as sub-module sync_fifo_4 with parameterised width.

Verification
REQ-029 SHALL cover: in_valid pulses with conv_y=10,-5,30,20, defaults, POOL_RELU_EN on -> outputs 10 then 30, each appearing 1 cycle after its second sample's y_valid.
REQ-030 SHALL cover: conv_y=-20,-3 with POOL_RELU_EN off -> output -3; with POOL_RELU_EN on -> output 0.
REQ-031 SHALL cover: 16 valid samples, defaults -> 8 outputs, only the 8th with out_last=1; the next 16 samples repeat the pattern.
REQ-032 SHALL cover: out_ready=0 with 10 pooled results produced -> 4 held in FIFO, overflow=1 from the 5th push, the FIFO contents are the first 4 results in order.
REQ-033 SHALL cover: full FIFO, out_ready=1 in the same cycle as a push -> no drop, overflow stays 0.
REQ-034 SHALL cover: rst_n asserted after 1 sample of a window -> after release, the next 2 samples form a fresh window and no stale value appears.
